// File: rtl/ysyx_23060061_mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM state, owner encoding, default widths.
// Round-robin arbitration is selected with YSYX_23060061_ARB_RR_EN.
package ysyx_23060061_mem_arbiter_pkg;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    function automatic owner_t other_owner(input owner_t owner);
        return (owner == OWN_IFU) ? OWN_LSU : OWN_IFU;
    endfunction

endpackage

// File: rtl/ysyx_23060061_mem_arbiter_if.sv
// Request/response handshake bundle shared by the IFU, LSU and memory sides of the arbiter.
// master = the side issuing requests, slave = the side serving them.
interface ysyx_23060061_mem_arbiter_if
    import ysyx_23060061_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_W-1:0]     addr;
    logic                  wen;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wmask;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req_valid, addr, wen, wdata, wmask, rsp_ready,
        input  req_ready, rsp_valid, rdata
    );

    modport slave (
        input  req_valid, addr, wen, wdata, wmask, rsp_ready,
        output req_ready, rsp_valid, rdata
    );

endinterface

// File: rtl/ysyx_23060061_arb_pick.sv
// Combinational winner selection between IFU and LSU requests.
// YSYX_23060061_ARB_RR_EN: contested grants alternate; otherwise the LSU always wins.
module ysyx_23060061_arb_pick
    import ysyx_23060061_mem_arbiter_pkg::*;
(
    input  logic   ifu_valid,
    input  logic   lsu_valid,
    input  owner_t last_owner,
    output logic   grant_valid,
    output owner_t grant_owner
);

`ifdef YSYX_23060061_ARB_RR_EN
    always_comb begin
        grant_valid = ifu_valid | lsu_valid;
        grant_owner = OWN_IFU;
        if (ifu_valid && lsu_valid) begin
            grant_owner = other_owner(last_owner);
        end else if (lsu_valid) begin
            grant_owner = OWN_LSU;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    // The LSU serves the older instruction, so it wins every contest.
    always_comb begin
        grant_valid = ifu_valid | lsu_valid;
        grant_owner = OWN_IFU;
        if (lsu_valid) begin
            grant_owner = OWN_LSU;
        end
    end
`endif

endmodule

// File: rtl/ysyx_23060061_mem_arbiter.sv
// Shares one memory port between IFU and LSU; one transaction in flight (IDLE -> REQ -> RESP).
// YSYX_23060061_ARB_RR_EN enables round-robin grants via a last_owner flop.
module ysyx_23060061_mem_arbiter
    import ysyx_23060061_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                          clk,
    input  logic                          rst,
    ysyx_23060061_mem_arbiter_if.slave    ifu,
    ysyx_23060061_mem_arbiter_if.slave    lsu,
    ysyx_23060061_mem_arbiter_if.master   mem,
    output logic                          busy
);

    arb_state_t            state_reg;
    owner_t                owner_reg;
    logic [ADDR_W-1:0]     addr_reg;
    logic                  wen_reg;
    logic [DATA_W-1:0]     wdata_reg;
    logic [DATA_W/8-1:0]   wmask_reg;
    logic                  mem_req_valid_reg;
    logic                  busy_reg;

    logic [ADDR_W-1:0]     addr_next;
    logic                  wen_next;
    logic [DATA_W-1:0]     wdata_next;
    logic [DATA_W/8-1:0]   wmask_next;

    logic                  grant_valid;
    owner_t                grant_owner;
    owner_t                last_owner;

    logic                  in_idle;
    logic                  in_resp;
    logic                  accept;
    logic                  owner_rsp_ready;
    logic                  rsp_done;

    logic                  unused_ifu_write;
    assign unused_ifu_write = ^{ifu.wen, ifu.wdata, ifu.wmask};

    ysyx_23060061_arb_pick u_pick (
        .ifu_valid   (ifu.req_valid),
        .lsu_valid   (lsu.req_valid),
        .last_owner  (last_owner),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // Readies are held low while reset is asserted even though the state reads IDLE.
    assign in_idle = (state_reg == IDLE) && rst;
    assign in_resp = (state_reg == RESP);
    assign accept  = in_idle && grant_valid;

    assign ifu.req_ready = in_idle && ifu.req_valid && (grant_owner == OWN_IFU);
    assign lsu.req_ready = in_idle && lsu.req_valid && (grant_owner == OWN_LSU);

    // Instruction fetches are always reads with an empty mask.
    always_comb begin
        addr_next  = ifu.addr;
        wen_next   = 1'b0;
        wdata_next = '0;
        wmask_next = '0;
        if (grant_owner == OWN_LSU) begin
            addr_next  = lsu.addr;
            wen_next   = lsu.wen;
            wdata_next = lsu.wdata;
            wmask_next = lsu.wmask;
        end
    end

    assign owner_rsp_ready = (owner_reg == OWN_LSU) ? lsu.rsp_ready : ifu.rsp_ready;
    assign rsp_done        = in_resp && mem.rsp_valid && owner_rsp_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg         <= IDLE;
            owner_reg         <= OWN_IFU;
            addr_reg          <= '0;
            wen_reg           <= 1'b0;
            wdata_reg         <= '0;
            wmask_reg         <= '0;
            mem_req_valid_reg <= 1'b0;
            busy_reg          <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg         <= REQ;
                        owner_reg         <= grant_owner;
                        addr_reg          <= addr_next;
                        wen_reg           <= wen_next;
                        wdata_reg         <= wdata_next;
                        wmask_reg         <= wmask_next;
                        mem_req_valid_reg <= 1'b1;
                        busy_reg          <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem.req_ready) begin
                        state_reg         <= RESP;
                        mem_req_valid_reg <= 1'b0;
                    end
                end
                RESP: begin
                    if (rsp_done) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg         <= IDLE;
                    mem_req_valid_reg <= 1'b0;
                    busy_reg          <= 1'b0;
                end
            endcase
        end
    end

`ifdef YSYX_23060061_ARB_RR_EN
    owner_t last_owner_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner_reg <= OWN_IFU;
        end else if (accept) begin
            last_owner_reg <= grant_owner;
        end
    end

    assign last_owner = last_owner_reg;
`else
    assign last_owner = OWN_IFU;
`endif

    assign mem.req_valid = mem_req_valid_reg;
    assign mem.addr      = addr_reg;
    assign mem.wen       = wen_reg;
    assign mem.wdata     = wdata_reg;
    assign mem.wmask     = wmask_reg;
    assign mem.rsp_ready = in_resp && owner_rsp_ready;

    // Response path is combinational from memory to the owner only.
    assign ifu.rsp_valid = in_resp && (owner_reg == OWN_IFU) && mem.rsp_valid;
    assign lsu.rsp_valid = in_resp && (owner_reg == OWN_LSU) && mem.rsp_valid;
    assign ifu.rdata     = (in_resp && (owner_reg == OWN_IFU)) ? mem.rdata : '0;
    assign lsu.rdata     = (in_resp && (owner_reg == OWN_LSU)) ? mem.rdata : '0;

    assign busy = busy_reg;

endmodule

// File: tb/tb_ysyx_23060061_mem_arbiter.sv
// Directed bench for ysyx_23060061_mem_arbiter; inputs change on the falling edge and
// outputs are sampled 1 time unit later, well away from the rising edge.
module tb_ysyx_23060061_mem_arbiter;

    logic clk;
    logic rst;
    logic busy;
    int   total;
    int   bad;
    logic last_lsu;
    logic exp_lsu;
    logic [31:0] exp_addr;

    ysyx_23060061_mem_arbiter_if ifu_bus ();
    ysyx_23060061_mem_arbiter_if lsu_bus ();
    ysyx_23060061_mem_arbiter_if mem_bus ();

    ysyx_23060061_mem_arbiter dut (
        .clk  (clk),
        .rst  (rst),
        .ifu  (ifu_bus),
        .lsu  (lsu_bus),
        .mem  (mem_bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs;
        ifu_bus.req_valid = 1'b0; ifu_bus.addr = '0; ifu_bus.wen = 1'b0;
        ifu_bus.wdata = '0; ifu_bus.wmask = '0; ifu_bus.rsp_ready = 1'b0;
        lsu_bus.req_valid = 1'b0; lsu_bus.addr = '0; lsu_bus.wen = 1'b0;
        lsu_bus.wdata = '0; lsu_bus.wmask = '0; lsu_bus.rsp_ready = 1'b0;
        mem_bus.req_ready = 1'b0; mem_bus.rsp_valid = 1'b0; mem_bus.rdata = '0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (mem_bus.req_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_req_valid got=%b want=0", mem_bus.req_valid); end
        total++; if (mem_bus.rsp_ready !== 1'b0) begin bad++; $display("FAIL reset_mem_rsp_ready got=%b want=0", mem_bus.rsp_ready); end
        total++; if (mem_bus.addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h want=0", mem_bus.addr); end
        total++; if ({ifu_bus.req_ready, lsu_bus.req_ready} !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b want=00", {ifu_bus.req_ready, lsu_bus.req_ready}); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_ifu_only;
        @(negedge clk);
        idle_inputs();
        ifu_bus.req_valid = 1'b1; ifu_bus.addr = 32'h8000_0000;
        #1;
        total++; if (ifu_bus.req_ready !== 1'b1) begin bad++; $display("FAIL ifu_only_req_ready got=%b want=1", ifu_bus.req_ready); end
        total++; if (lsu_bus.req_ready !== 1'b0) begin bad++; $display("FAIL ifu_only_lsu_ready got=%b want=0", lsu_bus.req_ready); end
        @(negedge clk);
        ifu_bus.req_valid = 1'b0; mem_bus.req_ready = 1'b1;
        #1;
        total++; if (mem_bus.req_valid !== 1'b1) begin bad++; $display("FAIL ifu_only_mem_req_valid got=%b want=1", mem_bus.req_valid); end
        total++; if (mem_bus.addr !== 32'h8000_0000) begin bad++; $display("FAIL ifu_only_mem_addr got=%h want=80000000", mem_bus.addr); end
        total++; if (mem_bus.wen !== 1'b0) begin bad++; $display("FAIL ifu_only_mem_wen got=%b want=0", mem_bus.wen); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ifu_only_busy got=%b want=1", busy); end
        @(negedge clk);
        mem_bus.req_ready = 1'b0; mem_bus.rsp_valid = 1'b1; mem_bus.rdata = 32'h0000_0413; ifu_bus.rsp_ready = 1'b1;
        #1;
        total++; if (ifu_bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL ifu_only_rsp_valid got=%b want=1", ifu_bus.rsp_valid); end
        total++; if (ifu_bus.rdata !== 32'h0000_0413) begin bad++; $display("FAIL ifu_only_rdata got=%h want=00000413", ifu_bus.rdata); end
        total++; if (mem_bus.rsp_ready !== 1'b1) begin bad++; $display("FAIL ifu_only_mem_rsp_ready got=%b want=1", mem_bus.rsp_ready); end
        total++; if (lsu_bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL ifu_only_lsu_rsp_valid got=%b want=0", lsu_bus.rsp_valid); end
        $display("xact ifu read addr=80000000 rdata=%h", ifu_bus.rdata);
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ifu_only_busy_after got=%b want=0", busy); end
        last_lsu = 1'b0;
    endtask

    task automatic test_simultaneous;
        @(negedge clk);
        idle_inputs();
        ifu_bus.req_valid = 1'b1; ifu_bus.addr = 32'h8000_0004;
        ifu_bus.wen = 1'b1; ifu_bus.wdata = 32'h1111_1111; ifu_bus.wmask = 4'hF;
        lsu_bus.req_valid = 1'b1; lsu_bus.addr = 32'h8000_1000; lsu_bus.wen = 1'b1;
        lsu_bus.wdata = 32'hDEAD_BEEF; lsu_bus.wmask = 4'b1111;
        #1;
        total++; if ({lsu_bus.req_ready, ifu_bus.req_ready} !== 2'b10) begin bad++; $display("FAIL simul_first_grant got=%b want=10", {lsu_bus.req_ready, ifu_bus.req_ready}); end
        @(negedge clk);
        lsu_bus.req_valid = 1'b0; mem_bus.req_ready = 1'b1;
        #1;
        total++; if (mem_bus.wen !== 1'b1) begin bad++; $display("FAIL simul_lsu_wen got=%b want=1", mem_bus.wen); end
        total++; if (mem_bus.addr !== 32'h8000_1000) begin bad++; $display("FAIL simul_lsu_addr got=%h want=80001000", mem_bus.addr); end
        total++; if (mem_bus.wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL simul_lsu_wdata got=%h want=deadbeef", mem_bus.wdata); end
        total++; if (mem_bus.wmask !== 4'hF) begin bad++; $display("FAIL simul_lsu_wmask got=%h want=f", mem_bus.wmask); end
        total++; if (ifu_bus.req_ready !== 1'b0) begin bad++; $display("FAIL simul_ifu_ready_in_req got=%b want=0", ifu_bus.req_ready); end
        @(negedge clk);
        mem_bus.req_ready = 1'b0; mem_bus.rsp_valid = 1'b1; mem_bus.rdata = '0; lsu_bus.rsp_ready = 1'b1; ifu_bus.rsp_ready = 1'b1;
        #1;
        total++; if ({lsu_bus.rsp_valid, ifu_bus.rsp_valid} !== 2'b10) begin bad++; $display("FAIL simul_lsu_rsp got=%b want=10", {lsu_bus.rsp_valid, ifu_bus.rsp_valid}); end
        $display("xact lsu write addr=80001000 wdata=deadbeef");
        @(negedge clk);
        mem_bus.rsp_valid = 1'b0;
        #1;
        total++; if (ifu_bus.req_ready !== 1'b1) begin bad++; $display("FAIL simul_ifu_second_grant got=%b want=1", ifu_bus.req_ready); end
        @(negedge clk);
        ifu_bus.req_valid = 1'b0; mem_bus.req_ready = 1'b1;
        #1;
        total++; if (mem_bus.addr !== 32'h8000_0004) begin bad++; $display("FAIL simul_ifu_addr got=%h want=80000004", mem_bus.addr); end
        total++; if ({mem_bus.wen, mem_bus.wmask} !== 5'b0) begin bad++; $display("FAIL simul_ifu_wen_wmask got=%b want=00000", {mem_bus.wen, mem_bus.wmask}); end
        total++; if (mem_bus.wdata !== 32'h0) begin bad++; $display("FAIL simul_ifu_wdata got=%h want=0", mem_bus.wdata); end
        @(negedge clk);
        mem_bus.req_ready = 1'b0; mem_bus.rsp_valid = 1'b1; mem_bus.rdata = 32'h1234_5678;
        #1;
        total++; if (ifu_bus.rdata !== 32'h1234_5678) begin bad++; $display("FAIL simul_ifu_rdata got=%h want=12345678", ifu_bus.rdata); end
        total++; if (lsu_bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL simul_nonowner_rsp got=%b want=0", lsu_bus.rsp_valid); end
        $display("xact ifu read addr=80000004 rdata=%h", ifu_bus.rdata);
        last_lsu = 1'b0;
    endtask

    task automatic test_contested;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_inputs();
            ifu_bus.req_valid = 1'b1; ifu_bus.addr = 32'h8000_0100 + 32'(i * 4);
            lsu_bus.req_valid = 1'b1; lsu_bus.addr = 32'h8000_2000 + 32'(i * 4);
`ifdef YSYX_23060061_ARB_RR_EN
            exp_lsu = ~last_lsu;
`else
            exp_lsu = 1'b1;
`endif
            last_lsu = exp_lsu;
            exp_addr = exp_lsu ? lsu_bus.addr : ifu_bus.addr;
            #1;
            total++; if ({lsu_bus.req_ready, ifu_bus.req_ready} !== {exp_lsu, ~exp_lsu}) begin bad++; $display("FAIL contested_grant[%0d] got=%b want=%b", i, {lsu_bus.req_ready, ifu_bus.req_ready}, {exp_lsu, ~exp_lsu}); end
            @(negedge clk);
            mem_bus.req_ready = 1'b1;
            #1;
            total++; if (mem_bus.addr !== exp_addr) begin bad++; $display("FAIL contested_addr[%0d] got=%h want=%h", i, mem_bus.addr, exp_addr); end
            @(negedge clk);
            mem_bus.req_ready = 1'b0; mem_bus.rsp_valid = 1'b1; mem_bus.rdata = 32'h100 + 32'(i);
            ifu_bus.rsp_ready = 1'b1; lsu_bus.rsp_ready = 1'b1;
            #1;
            total++; if ({lsu_bus.rsp_valid, ifu_bus.rsp_valid} !== {exp_lsu, ~exp_lsu}) begin bad++; $display("FAIL contested_rsp[%0d] got=%b want=%b", i, {lsu_bus.rsp_valid, ifu_bus.rsp_valid}, {exp_lsu, ~exp_lsu}); end
            $display("xact contested %0d owner=%s addr=%h", i, exp_lsu ? "lsu" : "ifu", exp_addr);
        end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        idle_inputs();
        lsu_bus.req_valid = 1'b1; lsu_bus.addr = 32'h8000_3000; lsu_bus.wen = 1'b1;
        lsu_bus.wdata = 32'hCAFE_F00D; lsu_bus.wmask = 4'b0011;
        #1;
        total++; if (lsu_bus.req_ready !== 1'b1) begin bad++; $display("FAIL bp_accept got=%b want=1", lsu_bus.req_ready); end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            lsu_bus.req_valid = 1'b0; lsu_bus.addr = 32'h0BAD_0000; lsu_bus.wdata = '0; lsu_bus.wmask = '0;
            mem_bus.req_ready = (c == 4);
            #1;
            total++; if ({mem_bus.req_valid, busy} !== 2'b11) begin bad++; $display("FAIL bp_req_valid_busy[%0d] got=%b want=11", c, {mem_bus.req_valid, busy}); end
            total++; if ({mem_bus.addr, mem_bus.wen, mem_bus.wdata, mem_bus.wmask} !== {32'h8000_3000, 1'b1, 32'hCAFE_F00D, 4'b0011}) begin
                bad++; $display("FAIL bp_req_stable[%0d] got=%h/%b/%h/%h want=80003000/1/cafef00d/3", c, mem_bus.addr, mem_bus.wen, mem_bus.wdata, mem_bus.wmask);
            end
        end
        for (int c = 5; c <= 7; c++) begin
            @(negedge clk);
            mem_bus.req_ready = 1'b0; mem_bus.rsp_valid = 1'b1; mem_bus.rdata = '0;
            lsu_bus.rsp_ready = (c == 7);
            #1;
            total++; if (mem_bus.rsp_ready !== lsu_bus.rsp_ready) begin bad++; $display("FAIL bp_rsp_ready[%0d] got=%b want=%b", c, mem_bus.rsp_ready, lsu_bus.rsp_ready); end
            total++; if ({lsu_bus.rsp_valid, busy, mem_bus.req_valid} !== 3'b110) begin bad++; $display("FAIL bp_resp_state[%0d] got=%b want=110", c, {lsu_bus.rsp_valid, busy, mem_bus.req_valid}); end
        end
        $display("xact lsu write addr=80003000 wdata=cafef00d with backpressure");
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if ({busy, mem_bus.req_valid} !== 2'b00) begin bad++; $display("FAIL bp_idle_after_8 got=%b want=00", {busy, mem_bus.req_valid}); end
    endtask

    task automatic test_stray_response;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            idle_inputs();
            mem_bus.rsp_valid = 1'b1; mem_bus.rdata = 32'h0000_0BAD;
            ifu_bus.rsp_ready = 1'b1; lsu_bus.rsp_ready = 1'b1;
            #1;
            total++; if ({mem_bus.rsp_ready, ifu_bus.rsp_valid, lsu_bus.rsp_valid} !== 3'b000) begin bad++; $display("FAIL stray_held_off[%0d] got=%b want=000", c, {mem_bus.rsp_ready, ifu_bus.rsp_valid, lsu_bus.rsp_valid}); end
            total++; if ({busy, mem_bus.req_valid} !== 2'b00) begin bad++; $display("FAIL stray_state[%0d] got=%b want=00", c, {busy, mem_bus.req_valid}); end
        end
        @(negedge clk);
        lsu_bus.req_valid = 1'b1; lsu_bus.addr = 32'h8000_4000; lsu_bus.wen = 1'b0;
        #1;
        total++; if (lsu_bus.req_ready !== 1'b1) begin bad++; $display("FAIL stray_then_grant got=%b want=1", lsu_bus.req_ready); end
        @(negedge clk);
        lsu_bus.req_valid = 1'b0;
        #1;
        total++; if ({mem_bus.req_valid, mem_bus.rsp_ready} !== 2'b10) begin bad++; $display("FAIL stray_in_req got=%b want=10", {mem_bus.req_valid, mem_bus.rsp_ready}); end
        @(negedge clk);
        mem_bus.req_ready = 1'b1;
        @(negedge clk);
        mem_bus.req_ready = 1'b0; mem_bus.rdata = 32'h55AA_55AA;
        #1;
        total++; if ({lsu_bus.rsp_valid, lsu_bus.rdata} !== {1'b1, 32'h55AA_55AA}) begin bad++; $display("FAIL stray_lsu_rsp got=%b/%h want=1/55aa55aa", lsu_bus.rsp_valid, lsu_bus.rdata); end
        $display("xact lsu read addr=80004000 rdata=%h", lsu_bus.rdata);
        last_lsu = 1'b1;
    endtask

    task automatic test_mid_reset;
        @(negedge clk);
        idle_inputs();
        ifu_bus.req_valid = 1'b1; ifu_bus.addr = 32'h8000_0040;
        @(negedge clk);
        ifu_bus.req_valid = 1'b0; mem_bus.req_ready = 1'b1;
        @(negedge clk);
        mem_bus.req_ready = 1'b0;
        #1;
        total++; if ({busy, mem_bus.req_valid} !== 2'b10) begin bad++; $display("FAIL midrst_in_resp got=%b want=10", {busy, mem_bus.req_valid}); end
        #1;
        rst = 1'b0;
        mem_bus.rsp_valid = 1'b1; ifu_bus.rsp_ready = 1'b1; ifu_bus.req_valid = 1'b1;
        #1;
        total++; if ({busy, mem_bus.req_valid, mem_bus.rsp_ready, ifu_bus.rsp_valid, ifu_bus.req_ready} !== 5'b0) begin
            bad++; $display("FAIL midrst_async_outputs got=%b want=00000", {busy, mem_bus.req_valid, mem_bus.rsp_ready, ifu_bus.rsp_valid, ifu_bus.req_ready});
        end
        total++; if (mem_bus.addr !== 32'h0) begin bad++; $display("FAIL midrst_latch_cleared got=%h want=0", mem_bus.addr); end
        @(negedge clk);
        rst = 1'b1;
        mem_bus.rsp_valid = 1'b0; ifu_bus.addr = 32'h8000_0080;
        #1;
        total++; if (ifu_bus.req_ready !== 1'b1) begin bad++; $display("FAIL midrst_regrant got=%b want=1", ifu_bus.req_ready); end
        @(negedge clk);
        ifu_bus.req_valid = 1'b0; mem_bus.req_ready = 1'b1;
        #1;
        total++; if (mem_bus.addr !== 32'h8000_0080) begin bad++; $display("FAIL midrst_regrant_addr got=%h want=80000080", mem_bus.addr); end
        @(negedge clk);
        mem_bus.req_ready = 1'b0; mem_bus.rsp_valid = 1'b1; mem_bus.rdata = 32'h0010_0073;
        #1;
        total++; if ({ifu_bus.rsp_valid, ifu_bus.rdata} !== {1'b1, 32'h0010_0073}) begin bad++; $display("FAIL midrst_regrant_rsp got=%b/%h want=1/00100073", ifu_bus.rsp_valid, ifu_bus.rdata); end
        $display("xact ifu read addr=80000080 rdata=%h after reset", ifu_bus.rdata);
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        last_lsu = 1'b0;
        exp_lsu  = 1'b0;
        exp_addr = '0;
        test_reset();
        test_ifu_only();
        test_simultaneous();
        test_contested();
        test_backpressure();
        test_stray_response();
        test_mid_reset();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
